// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_if
//  Description : Bundle of the instruction-sequencer signals: control inputs,
//                instruction-memory read port and execution-engine outputs.
//                The sequencer uses the master modport; its environment uses
//                the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [15:0]       imem_data;
    logic [3:0]        instr;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dest;
    logic              instr_valid;
    logic              op_done;
    logic              busy;
    logic              halted;
    logic              error;

    modport master (
        input  start,
        output imem_addr,
        output imem_rd,
        input  imem_data,
        output instr,
        output src_a,
        output src_b,
        output dest,
        output instr_valid,
        input  op_done,
        output busy,
        output halted,
        output error
    );

    modport slave (
        output start,
        input  imem_addr,
        input  imem_rd,
        output imem_data,
        input  instr,
        input  src_a,
        input  src_b,
        input  dest,
        input  instr_valid,
        output op_done,
        input  busy,
        input  halted,
        input  error
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Instruction fetch/sequencing stage. Walks a program counter
//                through synchronous instruction memory, presents each
//                instruction to the execution engine and holds it until the
//                datapath reports completion. Halts on the stop opcode, on
//                the last memory address or on a completion timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_sequencer_if.master  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_MEM  = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [2:0]        OP_STOP  = 3'b111;
    localparam logic [ADDR_W-1:0] PC_LAST  = '1;
    // The counter reaches TIMEOUT-1 on the last tolerated WAIT_DONE cycle,
    // so the halt lands after exactly TIMEOUT cycles without completion.
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [15:0]       tmo_q,   tmo_d;
    logic              err_q,   err_d;
    logic [15:0]       ir_q,    ir_d;

    // Next-state, program counter, timeout and instruction-register logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                ir_d    = bus.imem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // A stop word halts with pc left pointing at it.
                if (ir_q[15:13] == OP_STOP) begin
                    state_d = S_HALT;
                end else begin
                    tmo_d   = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.op_done) begin
                    if (pc_q == PC_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    err_d   = 1'b0;
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs come from registers or a pure decode of state, never from inputs
    assign bus.imem_addr   = pc_q;
    assign bus.imem_rd     = (state_q == S_FETCH);
    assign bus.instr_valid = (state_q == S_ISSUE);
    assign bus.busy        = (state_q == S_FETCH)    || (state_q == S_WAIT_MEM) ||
                             (state_q == S_ISSUE)    || (state_q == S_WAIT_DONE);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.error       = err_q;
    assign bus.instr       = ir_q[15:12];
    assign bus.src_a       = ir_q[11:8];
    assign bus.src_b       = ir_q[7:4];
    assign bus.dest        = ir_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed self-checking bench for instr_sequencer, built with
//                ADDR_W = 2 and TIMEOUT = 5 so memory-end and timeout
//                behaviour are reachable in a few cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    logic clk;
    logic reset;

    instr_sequencer_if #(.ADDR_W(2)) bus ();

    instr_sequencer #(
        .ADDR_W  (2),
        .TIMEOUT (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the read
    logic [15:0] mem [4];
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];
    end

    int n_cmp;
    int n_err;

    // Issue / fetch recording filled by run_prog
    logic [3:0] iss_instr [8];
    logic [3:0] iss_sa    [8];
    logic [3:0] iss_sb    [8];
    logic [3:0] iss_d     [8];
    int         iss_cyc   [8];
    logic [1:0] rd_addr   [8];
    int         n_iss;
    int         n_rd;
    bit         run_hung;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts the program and answers each issue with op_done one cycle later.
    // With spurious set, op_done is also raised in the start, FETCH and ISSUE
    // cycles and start is raised in WAIT_DONE.
    task automatic run_prog(input bit spurious);
        bit prev_iv;
        bit done;
        prev_iv  = 1'b0;
        done     = 1'b0;
        n_iss    = 0;
        n_rd     = 0;
        bus.start   = 1'b1;
        bus.op_done = spurious;
        for (int k = 0; k < 80 && !done; k++) begin
            step();
            bus.start   = 1'b0;
            bus.op_done = 1'b0;
            if (bus.imem_rd && n_rd < 8) begin
                rd_addr[n_rd] = bus.imem_addr;
                n_rd++;
            end
            if (bus.instr_valid && n_iss < 8) begin
                iss_instr[n_iss] = bus.instr;
                iss_sa[n_iss]    = bus.src_a;
                iss_sb[n_iss]    = bus.src_b;
                iss_d[n_iss]     = bus.dest;
                iss_cyc[n_iss]   = k;
                n_iss++;
            end
            if (bus.halted) begin
                done = 1'b1;
            end else begin
                if (prev_iv) begin
                    bus.op_done = 1'b1;
                    if (spurious) bus.start = 1'b1;
                end
                if (spurious && (bus.instr_valid || bus.imem_rd)) bus.op_done = 1'b1;
            end
            prev_iv = bus.instr_valid;
        end
        bus.start   = 1'b0;
        bus.op_done = 1'b0;
        run_hung    = !done;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op_done = 1'b0;
        #1;
        n_cmp++;
        if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted, bus.error,
             bus.instr, bus.src_a, bus.src_b, bus.dest, bus.imem_addr} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%b iv=%b busy=%b halt=%b err=%b instr=%h addr=%h, expected all 0",
                     bus.imem_rd, bus.instr_valid, bus.busy, bus.halted, bus.error, bus.instr, bus.imem_addr);
        end
        step();
        step();
        reset = 1'b0;
        step();
        step();
        n_cmp++;
        if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted, bus.error} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_outputs: got rd=%b iv=%b busy=%b halt=%b err=%b, expected all 0",
                     bus.imem_rd, bus.instr_valid, bus.busy, bus.halted, bus.error);
        end
    endtask

    task automatic test_stop();
        mem[0] = 16'hE000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.imem_rd, bus.imem_addr, bus.instr_valid, bus.busy} !== 5'b1_00_0_1) begin
            n_err++;
            $display("FAIL stop_fetch: got rd=%b addr=%0d iv=%b busy=%b, expected rd=1 addr=0 iv=0 busy=1",
                     bus.imem_rd, bus.imem_addr, bus.instr_valid, bus.busy);
        end
        step();
        n_cmp++;
        if ({bus.imem_rd, bus.instr_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL stop_waitmem: got rd=%b iv=%b, expected rd=0 iv=0", bus.imem_rd, bus.instr_valid);
        end
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr, bus.imem_rd, bus.halted} !== 7'b1_1110_0_0) begin
            n_err++;
            $display("FAIL stop_issue: got iv=%b instr=%b rd=%b halt=%b, expected iv=1 instr=1110 rd=0 halt=0",
                     bus.instr_valid, bus.instr, bus.imem_rd, bus.halted);
        end
        step();
        n_cmp++;
        if ({bus.halted, bus.instr_valid, bus.busy, bus.imem_addr, bus.instr} !== 9'b1_0_0_00_1110) begin
            n_err++;
            $display("FAIL stop_halt: got halt=%b iv=%b busy=%b addr=%0d instr=%b, expected halt=1 iv=0 busy=0 addr=0 instr=1110",
                     bus.halted, bus.instr_valid, bus.busy, bus.imem_addr, bus.instr);
        end
        step();
        n_cmp++;
        if ({bus.halted, bus.imem_rd, bus.error} !== 3'b100) begin
            n_err++;
            $display("FAIL stop_stay_halted: got halt=%b rd=%b err=%b, expected halt=1 rd=0 err=0",
                     bus.halted, bus.imem_rd, bus.error);
        end
    endtask

    // Shared expectations for the three-instruction program
    task automatic check_program(input string tag);
        n_cmp++;
        if (run_hung !== 1'b0 || n_iss !== 3 || n_rd !== 3) begin
            n_err++;
            $display("FAIL %s_counts: got hung=%b issues=%0d reads=%0d, expected hung=0 issues=3 reads=3",
                     tag, run_hung, n_iss, n_rd);
        end
        n_cmp++;
        if ({iss_instr[0], iss_instr[1], iss_instr[2]} !== 12'b0000_0010_1110) begin
            n_err++;
            $display("FAIL %s_instr: got %b %b %b, expected 0000 0010 1110",
                     tag, iss_instr[0], iss_instr[1], iss_instr[2]);
        end
        n_cmp++;
        if ({iss_sa[0], iss_sb[0], iss_d[0], iss_sa[1], iss_sb[1], iss_d[1]} !== 24'h123456) begin
            n_err++;
            $display("FAIL %s_operands: got %h%h%h %h%h%h, expected 123 456", tag,
                     iss_sa[0], iss_sb[0], iss_d[0], iss_sa[1], iss_sb[1], iss_d[1]);
        end
        n_cmp++;
        if (iss_cyc[0] !== 2 || iss_cyc[1] - iss_cyc[0] !== 4 || iss_cyc[2] - iss_cyc[1] !== 4) begin
            n_err++;
            $display("FAIL %s_timing: got issue cycles %0d %0d %0d, expected 2 6 10",
                     tag, iss_cyc[0], iss_cyc[1], iss_cyc[2]);
        end
        n_cmp++;
        if ({rd_addr[0], rd_addr[1], rd_addr[2]} !== 6'b00_01_10) begin
            n_err++;
            $display("FAIL %s_addrs: got %0d %0d %0d, expected 0 1 2", tag, rd_addr[0], rd_addr[1], rd_addr[2]);
        end
        n_cmp++;
        if ({bus.halted, bus.error, bus.busy, bus.instr, bus.imem_addr} !== 9'b1_0_0_1110_10) begin
            n_err++;
            $display("FAIL %s_final: got halt=%b err=%b busy=%b instr=%b addr=%0d, expected halt=1 err=0 busy=0 instr=1110 addr=2",
                     tag, bus.halted, bus.error, bus.busy, bus.instr, bus.imem_addr);
        end
    endtask

    task automatic test_program();
        mem[0] = 16'h0123;
        mem[1] = 16'h2456;
        mem[2] = 16'hE000;
        mem[3] = 16'h0000;
        run_prog(1'b0);
        check_program("prog");
    endtask

    task automatic test_full_mem();
        mem[0] = 16'h0123;
        mem[1] = 16'h2456;
        mem[2] = 16'h4789;
        mem[3] = 16'h6ABC;
        run_prog(1'b0);
        n_cmp++;
        if (run_hung !== 1'b0 || n_iss !== 4 || n_rd !== 4) begin
            n_err++;
            $display("FAIL full_counts: got hung=%b issues=%0d reads=%0d, expected hung=0 issues=4 reads=4",
                     run_hung, n_iss, n_rd);
        end
        n_cmp++;
        if ({iss_instr[0], iss_instr[1], iss_instr[2], iss_instr[3]} !== 16'b0000_0010_0100_0110) begin
            n_err++;
            $display("FAIL full_instr: got %b %b %b %b, expected 0000 0010 0100 0110",
                     iss_instr[0], iss_instr[1], iss_instr[2], iss_instr[3]);
        end
        n_cmp++;
        if ({rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]} !== 8'b00_01_10_11) begin
            n_err++;
            $display("FAIL full_addrs: got %0d %0d %0d %0d, expected 0 1 2 3",
                     rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]);
        end
        step();
        step();
        n_cmp++;
        if ({bus.halted, bus.error, bus.imem_rd, bus.imem_addr, bus.dest} !== 9'b1_0_0_11_1100) begin
            n_err++;
            $display("FAIL full_final: got halt=%b err=%b rd=%b addr=%0d dest=%h, expected halt=1 err=0 rd=0 addr=3 dest=c",
                     bus.halted, bus.error, bus.imem_rd, bus.imem_addr, bus.dest);
        end
    endtask

    task automatic test_timeout();
        mem[0] = 16'h0123;
        bus.op_done = 1'b0;
        bus.start   = 1'b1;
        step();                 // FETCH
        bus.start = 1'b0;
        step();                 // WAIT_MEM
        step();                 // ISSUE
        n_cmp++;
        if (bus.instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_issue: got iv=%b, expected 1", bus.instr_valid);
        end
        for (int i = 0; i < 5; i++) step();   // five WAIT_DONE cycles
        n_cmp++;
        if ({bus.busy, bus.halted, bus.error} !== 3'b100) begin
            n_err++;
            $display("FAIL tmo_last_wait: got busy=%b halt=%b err=%b, expected busy=1 halt=0 err=0",
                     bus.busy, bus.halted, bus.error);
        end
        step();
        n_cmp++;
        if ({bus.busy, bus.halted, bus.error} !== 3'b011) begin
            n_err++;
            $display("FAIL tmo_halt: got busy=%b halt=%b err=%b, expected busy=0 halt=1 err=1",
                     bus.busy, bus.halted, bus.error);
        end
        step();
        n_cmp++;
        if ({bus.halted, bus.error} !== 2'b11) begin
            n_err++;
            $display("FAIL tmo_sticky: got halt=%b err=%b, expected halt=1 err=1", bus.halted, bus.error);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.error, bus.halted, bus.imem_rd, bus.imem_addr} !== 5'b0_0_1_00) begin
            n_err++;
            $display("FAIL tmo_restart: got err=%b halt=%b rd=%b addr=%0d, expected err=0 halt=0 rd=1 addr=0",
                     bus.error, bus.halted, bus.imem_rd, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem[0] = 16'h2456;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();                 // first WAIT_DONE cycle
        n_cmp++;
        if ({bus.busy, bus.instr, bus.src_a} !== 9'b1_0010_0100) begin
            n_err++;
            $display("FAIL rmid_pre: got busy=%b instr=%b src_a=%h, expected busy=1 instr=0010 src_a=4",
                     bus.busy, bus.instr, bus.src_a);
        end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted, bus.error,
             bus.instr, bus.src_a, bus.src_b, bus.dest, bus.imem_addr} !== 23'd0) begin
            n_err++;
            $display("FAIL rmid_async: got busy=%b instr=%b src_a=%h src_b=%h dest=%h addr=%0d, expected all 0",
                     bus.busy, bus.instr, bus.src_a, bus.src_b, bus.dest, bus.imem_addr);
        end
        step();
        reset     = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.imem_rd, bus.imem_addr} !== 3'b1_00) begin
            n_err++;
            $display("FAIL rmid_restart: got rd=%b addr=%0d, expected rd=1 addr=0", bus.imem_rd, bus.imem_addr);
        end
    endtask

    task automatic test_spurious();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.op_done = 1'b1;     // op_done alone in IDLE
        step();
        bus.op_done = 1'b0;
        step();
        n_cmp++;
        if ({bus.busy, bus.imem_rd, bus.halted} !== 3'b000) begin
            n_err++;
            $display("FAIL spur_idle: got busy=%b rd=%b halt=%b, expected all 0", bus.busy, bus.imem_rd, bus.halted);
        end
        mem[0] = 16'h0123;
        mem[1] = 16'h2456;
        mem[2] = 16'hE000;
        mem[3] = 16'h0000;
        run_prog(1'b1);
        check_program("spur");
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.start   = 1'b0;
        bus.op_done = 1'b0;
        reset       = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
        test_reset();
        test_stop();
        test_program();
        test_full_mem();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
